// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
//
// Serial-to-parallel SPI slave front end. MOSI is sampled on every rising edge
// of the system clock while SS_n is low. Each frame is one discarded dummy bit
// followed by a 10-bit word, MSB first. The word is presented on rx_data with
// rx_valid. Bits [9:8] of the word are the command and bits [7:0] the payload.
//
// A read is two frames:
//   - A read-address frame (first bit 1, rd_addr_done clear). It sets
//     rd_addr_done.
//   - A read-data frame (first bit 1, rd_addr_done set). It clears
//     rd_addr_done.
// After a read-data word completes, the first tx_valid latches tx_data. That
// byte is then shifted out on MISO, MSB first, one bit per clock.
//
// Ports
//   clk       in   1   system clock, rising edge
//   rst_n     in   1   asynchronous active-low reset
//   MOSI      in   1   serial data from master, MSB first
//   MISO      out  1   serial reply to master, MSB first; 0 when idle
//   SS_n      in   1   slave select, active low
//   rx_valid  out  1   rx_data holds a complete word (held until SS_n high)
//   rx_data   out  10  last complete received word
//   tx_valid  in   1   tx_data carries the read-data reply
//   tx_data   in   8   reply byte
// -----------------------------------------------------------------------------
module spi_slave (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       MOSI,
    output logic       MISO,
    input  logic       SS_n,
    output logic       rx_valid,
    output logic [9:0] rx_data,
    input  logic       tx_valid,
    input  logic [7:0] tx_data
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    state_t      state_q, state_d;

    // Receive path.
    // The shifter only needs the first nine bits. The tenth bit is taken
    // straight from MOSI when the word is loaded into rx_data.
    logic [8:0]  shift_q, shift_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic        word_done_q, word_done_d;   // word of this frame completed
    logic [9:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rd_addr_done_q, rd_addr_done_d;

    // Reply path
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic [3:0]  tx_cnt_q, tx_cnt_d;         // reply bits still to send
    logic        tx_busy_q, tx_busy_d;       // reply shifting out
    logic        tx_used_q, tx_used_d;       // reply already taken this frame
    logic        miso_q, miso_d;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (SS_n) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:      state_d = CHK_CMD;
                // The first data bit selects write versus read. rd_addr_done
                // then decides whether a read carries an address or data.
                CHK_CMD: begin
                    if (!MOSI) begin
                        state_d = WRITE;
                    end else if (rd_addr_done_q) begin
                        state_d = READ_DATA;
                    end else begin
                        state_d = READ_ADD;
                    end
                end
                WRITE:     state_d = WRITE;
                READ_ADD:  state_d = READ_ADD;
                READ_DATA: state_d = READ_DATA;
                default:   state_d = IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output / datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        shift_d        = shift_q;
        bit_cnt_d      = bit_cnt_q;
        word_done_d    = word_done_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = rx_valid_q;
        rd_addr_done_d = rd_addr_done_q;
        tx_shift_d     = tx_shift_q;
        tx_cnt_d       = tx_cnt_q;
        tx_busy_d      = tx_busy_q;
        tx_used_d      = tx_used_q;
        miso_d         = 1'b0;

        if (SS_n) begin
            // End of frame, or an aborted frame. rx_data and rd_addr_done
            // keep their values. Everything tied to the frame is cleared.
            bit_cnt_d   = 4'd0;
            word_done_d = 1'b0;
            rx_valid_d  = 1'b0;
            tx_busy_d   = 1'b0;
            tx_used_d   = 1'b0;
            tx_cnt_d    = 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    // The dummy bit is discarded.
                    bit_cnt_d   = 4'd0;
                    word_done_d = 1'b0;
                end
                CHK_CMD: begin
                    shift_d   = {shift_q[7:0], MOSI};
                    bit_cnt_d = 4'd1;
                end
                WRITE, READ_ADD, READ_DATA: begin
                    if (!word_done_q) begin
                        if (bit_cnt_q == 4'd9) begin
                            // Tenth bit: load the whole word in parallel.
                            rx_data_d   = {shift_q, MOSI};
                            rx_valid_d  = 1'b1;
                            word_done_d = 1'b1;
                            bit_cnt_d   = 4'd10;
                            if (state_q == READ_ADD) begin
                                rd_addr_done_d = 1'b1;
                            end else if (state_q == READ_DATA) begin
                                rd_addr_done_d = 1'b0;
                            end
                        end else begin
                            shift_d   = {shift_q[7:0], MOSI};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end else if (state_q == READ_DATA) begin
                        // Reply phase. Only one byte is taken per frame.
                        // MISO is registered, so each bit appears one edge
                        // after it reaches tx_shift_q[7].
                        if (tx_busy_q) begin
                            miso_d     = tx_shift_q[7];
                            tx_shift_d = {tx_shift_q[6:0], 1'b0};
                            tx_cnt_d   = tx_cnt_q - 4'd1;
                            if (tx_cnt_q == 4'd1) begin
                                tx_busy_d = 1'b0;
                            end
                        end else if (!tx_used_q && tx_valid) begin
                            tx_shift_d = tx_data;
                            tx_cnt_d   = 4'd8;
                            tx_busy_d  = 1'b1;
                            tx_used_d  = 1'b1;
                        end
                    end
                end
                default: begin
                    bit_cnt_d = 4'd0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q        <= 9'd0;
            bit_cnt_q      <= 4'd0;
            word_done_q    <= 1'b0;
            rx_data_q      <= 10'd0;
            rx_valid_q     <= 1'b0;
            rd_addr_done_q <= 1'b0;
            tx_shift_q     <= 8'd0;
            tx_cnt_q       <= 4'd0;
            tx_busy_q      <= 1'b0;
            tx_used_q      <= 1'b0;
            miso_q         <= 1'b0;
        end else begin
            shift_q        <= shift_d;
            bit_cnt_q      <= bit_cnt_d;
            word_done_q    <= word_done_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rd_addr_done_q <= rd_addr_done_d;
            tx_shift_q     <= tx_shift_d;
            tx_cnt_q       <= tx_cnt_d;
            tx_busy_q      <= tx_busy_d;
            tx_used_q      <= tx_used_d;
            miso_q         <= miso_d;
        end
    end

    assign MISO     = miso_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;

endmodule

// File: tb/tb_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_slave
//
// Directed checks of spi_slave:
//   - reset values
//   - write, read-address and read-data frames, including the MISO reply
//   - extra bits after a word, and aborted frames
//   - reset in the middle of a frame
//
// These are followed by a run of random frames, aborts and resets that are
// checked against a small reference model. Inputs change on the falling edge.
// Outputs are sampled on the falling edge after the rising edge of interest.
// -----------------------------------------------------------------------------
module tb_spi_slave;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b1;
    logic       MOSI     = 1'b0;
    logic       SS_n     = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       MISO;
    logic       rx_valid;
    logic [9:0] rx_data;

    int n_checks = 0;
    int n_fail   = 0;

    spi_slave dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .SS_n     (SS_n),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .tx_valid (tx_valid),
        .tx_data  (tx_data)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Drive one bit at the current falling edge and advance to the next one,
    // so exactly one rising edge samples it.
    task automatic drive(input logic ss, input logic b);
        SS_n = ss;
        MOSI = b;
        @(negedge clk);
    endtask

    // Dummy bit plus a 10-bit word. Returns just after the completing edge,
    // with SS_n still low.
    task automatic send_word(input logic [9:0] w, input logic dummy);
        drive(1'b0, dummy);
        for (int i = 9; i >= 0; i--) drive(1'b0, w[i]);
    endtask

    // Request a reply and check that MISO stays 0 for several edges.
    task automatic expect_no_reply(input string tag, input logic [7:0] byte_v);
        tx_data  = byte_v;
        tx_valid = 1'b1;
        drive(1'b0, 1'b0);
        tx_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 1'b0);
            check_eq(tag, 32'(MISO), 32'd0);
        end
    endtask

    // Request a reply and check all 8 reply bits, then the return to 0.
    task automatic expect_reply(input logic [7:0] byte_v);
        tx_data  = byte_v;
        tx_valid = 1'b1;
        drive(1'b0, 1'b0);            // latch edge
        tx_valid = 1'b0;
        check_eq("miso_latch", 32'(MISO), 32'd0);
        for (int i = 7; i >= 0; i--) begin
            drive(1'b0, 1'b0);
            check_eq("miso_bit", 32'(MISO), 32'(byte_v[i]));
        end
        drive(1'b0, 1'b0);
        check_eq("miso_after", 32'(MISO), 32'd0);
        $display("reply 0x%02h checked", byte_v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [9:0] w;
        logic [9:0] m_data;
        int         r;
        int         k;

        // ---------------- reset (asynchronous, before any clock edge) -------
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_miso", 32'(MISO), 32'd0);
        check_eq("rst_data", 32'(rx_data), 32'd0);
        check_eq("rst_valid", 32'(rx_valid), 32'd0);
        repeat (3) @(negedge clk);
        check_eq("rst_hold_data", 32'(rx_data), 32'd0);
        rst_n = 1'b1;
        drive(1'b1, 1'b0);
        $display("reset checked");

        // ---------------- write frame ---------------------------------------
        send_word(10'b0011111111, 1'b0);
        check_eq("wr_valid", 32'(rx_valid), 32'd1);
        check_eq("wr_data", 32'(rx_data), 32'h0FF);
        check_eq("wr_miso", 32'(MISO), 32'd0);
        drive(1'b0, 1'b0);
        check_eq("wr_valid_hold", 32'(rx_valid), 32'd1);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1);   // extra bits ignored
        check_eq("wr_extra_data", 32'(rx_data), 32'h0FF);
        check_eq("wr_extra_valid", 32'(rx_valid), 32'd1);
        drive(1'b1, 1'b0);
        check_eq("wr_ss_high_valid", 32'(rx_valid), 32'd0);
        repeat (10) drive(1'b1, 1'b0);
        check_eq("wr_idle_valid", 32'(rx_valid), 32'd0);
        check_eq("wr_idle_data", 32'(rx_data), 32'h0FF);
        $display("write frame 0x0FF checked");

        // ---------------- read address, then read data ----------------------
        send_word({2'b10, 8'h3C}, 1'b1);
        check_eq("rda_data", 32'(rx_data), 32'h23C);
        check_eq("rda_valid", 32'(rx_valid), 32'd1);
        drive(1'b1, 1'b0);
        send_word({2'b11, 8'h00}, 1'b0);
        check_eq("rdd_data", 32'(rx_data), 32'h300);
        check_eq("rdd_valid", 32'(rx_valid), 32'd1);
        expect_reply(8'hA5);
        expect_no_reply("rdd_second_req", 8'hFF);   // one reply per frame
        drive(1'b1, 1'b0);
        $display("read address 0x23C / read data 0x300 checked");

        // rd_addr_done is clear again, so this frame is a read address.
        send_word({2'b11, 8'h55}, 1'b0);
        check_eq("rda2_data", 32'(rx_data), 32'h355);
        expect_no_reply("rda2_no_reply", 8'hFF);
        drive(1'b1, 1'b0);
        $display("read address 0x355 checked");

        // ---------------- abort ---------------------------------------------
        drive(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1);
        drive(1'b1, 1'b0);
        check_eq("abort_valid", 32'(rx_valid), 32'd0);
        check_eq("abort_data", 32'(rx_data), 32'h355);
        $display("abort checked");
        send_word(10'b0001010101, 1'b1);
        check_eq("post_abort_data", 32'(rx_data), 32'h055);
        check_eq("post_abort_valid", 32'(rx_valid), 32'd1);
        drive(1'b1, 1'b0);
        // The abort and the write must both leave rd_addr_done set.
        send_word({2'b11, 8'h0F}, 1'b0);
        check_eq("rdd2_data", 32'(rx_data), 32'h30F);
        expect_reply(8'h3C);
        drive(1'b1, 1'b0);
        $display("write 0x055 / read data 0x30F checked");

        // ---------------- reset mid-frame -----------------------------------
        drive(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_data", 32'(rx_data), 32'd0);
        check_eq("midrst_valid", 32'(rx_valid), 32'd0);
        check_eq("midrst_miso", 32'(MISO), 32'd0);
        @(negedge clk);
        SS_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b0);
        send_word(10'h2AA, 1'b0);
        check_eq("postrst_data", 32'(rx_data), 32'h2AA);
        check_eq("postrst_valid", 32'(rx_valid), 32'd1);
        drive(1'b1, 1'b0);
        $display("reset mid-frame checked");

        // ---------------- random frames against a model --------------------
        m_data = 10'h2AA;
        for (int f = 0; f < 1500; f++) begin
            r = $urandom_range(0, 9);
            k = $urandom_range(0, 2);
            repeat (k) drive(1'b1, 1'b0);
            if (r == 0) begin
                #2 rst_n = 1'b0;
                #1;
                m_data = 10'd0;
                check_eq("rnd_rst_data", 32'(rx_data), 32'(m_data));
                check_eq("rnd_rst_valid", 32'(rx_valid), 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
                drive(1'b1, 1'b0);
                $display("rnd %0d reset", f);
            end else if (r == 1) begin
                k = $urandom_range(1, 9);
                drive(1'b0, 1'($urandom));
                for (int i = 0; i < k; i++) drive(1'b0, 1'($urandom));
                drive(1'b1, 1'b0);
                check_eq("rnd_abort_valid", 32'(rx_valid), 32'd0);
                check_eq("rnd_abort_data", 32'(rx_data), 32'(m_data));
                $display("rnd %0d abort after %0d bits", f, k);
            end else begin
                w = 10'($urandom);
                send_word(w, 1'($urandom));
                m_data = w;
                check_eq("rnd_valid", 32'(rx_valid), 32'd1);
                check_eq("rnd_data", 32'(rx_data), 32'(m_data));
                check_eq("rnd_miso", 32'(MISO), 32'd0);
                drive(1'b1, 1'b0);
                check_eq("rnd_end_valid", 32'(rx_valid), 32'd0);
                check_eq("rnd_end_data", 32'(rx_data), 32'(m_data));
                $display("rnd %0d frame 0x%03h", f, w);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
